display_ndigit_mux: RTL and testbench
=====================================

Name: display_ndigit_mux

Overview:
Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display with active-low segment and digit-select pins. It scans the digits from a 4-bit-per-digit hex value, with:
- per-digit decimal points
- optional leading-zero blanking
- per-digit blinking
- PWM brightness control
- tear-free frame-synchronous input capture

It sits between game/score logic and the board display pins. It is the general successor to the fixed 4-digit scanner.

Parameters:
- NDIG, 4, number of digits scanned (legal 2..8).
- DWELL_W, 17, prescaler width; each digit is selected for 2^DWELL_W clk cycles.
- BRIGHT_W, 3, brightness control width.
- BLINK_W, 5, frame-counter width; blink period is 2^BLINK_W frames, 50% duty.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- value, input, 4*NDIG: hex digits; nibble k drives digit k (digit 0 is rightmost, least significant).
- dp_in, input, NDIG: decimal point request per digit, active-high.
- blink_en, input, NDIG: per-digit blink enable, active-high.
- blank_lz, input, 1: 1 = suppress leading zeros.
- brightness, input, BRIGHT_W: 0 = dimmest, all-ones = full on.
- enable, input, 1: 0 = display dark; scanning continues.
- segments, output, 8: active-low, bit7..0 = a,b,c,d,e,f,g,dp.
- digitselect, output, NDIG: active-low one-cold digit enable.
- frame_tick, output, 1: one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (async assert, sync-safe release):
  - prescaler, digit index, frame counter and snapshot registers all clear to 0.
  - segments = 8'hFF, digitselect = all ones, frame_tick = 0.
- Prescaler: counts 0..2^DWELL_W-1 and wraps. On wrap, the digit index advances 0,1,..,NDIG-1,0.
- Snapshot:
  - When the prescaler wraps while index = NDIG-1, value/dp_in/blink_en/blank_lz are registered into shadow copies, the frame counter increments (wrapping at 2^BLINK_W), and frame_tick pulses for that one cycle.
  - All display decoding uses the shadows only, so mid-frame input changes never appear until the next frame.
  - The first snapshot occurs at the end of the first frame after reset; until then the shadows are 0.
- Per-cycle "lit" decision for the current digit k. lit = 1 only if all of the following hold:
  - enable = 1;
  - prescaler != 0 (one-cycle anti-ghost gap at each dwell start);
  - prescaler[DWELL_W-1 -: BRIGHT_W] <= brightness (duty = (brightness+1)/2^BRIGHT_W);
  - NOT (blink shadow[k] = 1 AND frame counter MSB = 1).
- Leading-zero blanking:
  - When blank_lz shadow = 1, digit k's glyph is suppressed if every nibble from k up to NDIG-1 is 0 and k != 0. Digit 0 always shows its glyph.
  - The dp of a suppressed digit is still driven per dp_in.
- Output encoding:
  - If lit: digitselect = ~(1<<k); segments = ~{glyph(nibble k) or 7'b0 if suppressed, dp shadow[k]}.
  - Else: digitselect = all ones, segments = 8'hFF.
- Glyphs (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Latency: outputs are registered; pins reflect the prescaler/index state of the previous cycle (1-cycle latency).
- enable: has no effect on counters or snapshot; only forces outputs dark from the next cycle.
- Reset mid-frame: outputs go dark immediately (async) and scanning restarts at digit 0.

Decomposition:
- Shared package display_pkg holds:
  - the 16-entry glyph constant table;
  - segment bit-position constants SEG_A..SEG_DP;
  - the SEG_OFF = 8'hFF constant.
- One combinational sub-module, hex_to_7seg_lut (4-bit in, 7-bit active-high glyph out), instantiated once on the selected nibble.

Test Plan (NDIG=4, DWELL_W=4, BRIGHT_W=2, BLINK_W=2):
- Reset held, then released with value=16'h12AF, enable=1, brightness=3 -> frame 0 shows digit 0 glyph "0" (shadow 0); after frame_tick, digit 0 segments = ~8'b10001110 (F) with digitselect=4'b1110, and digit 3 = ~8'b01100000 (1).
- value=16'h0070, blank_lz=1, dp_in=4'b0100 -> digit 3 fully dark; digit 2 segments = ~8'b00000001 (dp only); digit 1 shows 7; digit 0 shows 0.
- brightness=0 -> digitselect low for exactly 3 of 16 cycles per dwell (cycles 1..3); brightness=3 -> low for 15 of 16 cycles.
- blink_en=4'b0001 -> digit 0 lit for frames with frame counter 0,1 and dark for 2,3; other digits are unaffected.
- Change value at mid-frame (digit 1 active) -> displayed value changes only after the next frame_tick; the pulse is exactly 1 cycle, every 64 cycles.
- enable=0 mid-frame -> segments=8'hFF and digitselect=4'hF from the next cycle, while frame_tick cadence continues; assert rst_n=0 mid-dwell -> outputs dark in the same cycle.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display drivers.
// Holds the glyph table, the segment bit positions and the all-dark pin pattern.
package display_pkg;

    localparam int unsigned SEG_W   = 8;
    localparam int unsigned GLYPH_W = 7;

    // Segment bit positions on the pins: bit7..0 = a,b,c,d,e,f,g,dp
    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_B  = 6;
    localparam int unsigned SEG_C  = 5;
    localparam int unsigned SEG_D  = 4;
    localparam int unsigned SEG_E  = 3;
    localparam int unsigned SEG_F  = 2;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

    // Active-high glyphs, bit6..0 = a,b,c,d,e,f,g
    localparam logic [GLYPH_W-1:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/hex_to_7seg_lut.sv
// Combinational hex nibble to active-high abcdefg glyph lookup.
module hex_to_7seg_lut
    import display_pkg::*;
(
    input  logic [3:0]         nibble,
    output logic [GLYPH_W-1:0] glyph_c
);

    assign glyph_c = GLYPH[nibble];

endmodule

// File: rtl/display_ndigit_mux.sv
// N-digit multiplexed common-anode 7-segment driver with blanking, blink and PWM.
// Inputs are captured once per frame so a frame never mixes old and new digits.
module display_ndigit_mux
    import display_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned DWELL_W  = 17,
    parameter int unsigned BRIGHT_W = 3,
    parameter int unsigned BLINK_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   value,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     blink_en,
    input  logic                blank_lz,
    input  logic [BRIGHT_W-1:0] brightness,
    input  logic                enable,
    output logic [SEG_W-1:0]    segments,
    output logic [NDIG-1:0]     digitselect,
    output logic                frame_tick
);

    localparam int unsigned IDX_W = $clog2(NDIG);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [DWELL_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLINK_W-1:0] frame_q, frame_d;
    logic               snap_c;

    logic [4*NDIG-1:0]  val_sh_q;
    logic [NDIG-1:0]    dp_sh_q;
    logic [NDIG-1:0]    blink_sh_q;
    logic               blz_sh_q;

    logic [3:0]         nib_c;
    logic               dp_c, blink_c, supp_c, zero_run_c;
    logic [GLYPH_W-1:0] glyph_c, glyph_m_c;
    logic               lit_c;
    logic [SEG_W-1:0]   seg_d;
    logic [NDIG-1:0]    dsel_d;

    hex_to_7seg_lut u_lut (
        .nibble  (nib_c),
        .glyph_c (glyph_c)
    );

    // Scan counters: prescaler wrap steps the digit, last-digit wrap closes the frame
    always_comb begin
        presc_d = presc_q + DWELL_W'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        snap_c  = 1'b0;
        if (presc_q == '1) begin
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                frame_d = frame_q + BLINK_W'(1);
                snap_c  = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Select current digit's shadow data; zero run tracks "all nibbles from k upward are 0"
    always_comb begin
        nib_c      = '0;
        dp_c       = 1'b0;
        blink_c    = 1'b0;
        supp_c     = 1'b0;
        zero_run_c = 1'b1;
        for (int k = int'(NDIG) - 1; k >= 0; k--) begin
            zero_run_c = zero_run_c && (val_sh_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) begin
                nib_c   = val_sh_q[4*k +: 4];
                dp_c    = dp_sh_q[k];
                blink_c = blink_sh_q[k];
                supp_c  = blz_sh_q && zero_run_c && (k != 0);
            end
        end
    end

    // Lit decision and pin encoding for the next cycle
    always_comb begin
        lit_c = enable
             && (presc_q != '0)
             && (presc_q[DWELL_W-1 -: BRIGHT_W] <= brightness)
             && !(blink_c && frame_q[BLINK_W-1]);
        glyph_m_c = supp_c ? '0 : glyph_c;
        seg_d     = SEG_OFF;
        dsel_d    = '1;
        if (lit_c) begin
            dsel_d         = ~(NDIG'(1) << idx_q);
            seg_d[SEG_A]   = ~glyph_m_c[6];
            seg_d[SEG_B]   = ~glyph_m_c[5];
            seg_d[SEG_C]   = ~glyph_m_c[4];
            seg_d[SEG_D]   = ~glyph_m_c[3];
            seg_d[SEG_E]   = ~glyph_m_c[2];
            seg_d[SEG_F]   = ~glyph_m_c[1];
            seg_d[SEG_G]   = ~glyph_m_c[0];
            seg_d[SEG_DP]  = ~dp_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            val_sh_q    <= '0;
            dp_sh_q     <= '0;
            blink_sh_q  <= '0;
            blz_sh_q    <= 1'b0;
            segments    <= SEG_OFF;
            digitselect <= '1;
            frame_tick  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            segments    <= seg_d;
            digitselect <= dsel_d;
            frame_tick  <= snap_c;
            if (snap_c) begin
                val_sh_q   <= value;
                dp_sh_q    <= dp_in;
                blink_sh_q <= blink_en;
                blz_sh_q   <= blank_lz;
            end
        end
    end

endmodule

// File: tb/tb_display_ndigit_mux.sv
// Self-checking bench for display_ndigit_mux (NDIG=4, DWELL_W=4, BRIGHT_W=2, BLINK_W=2).
`timescale 1ns/1ps
module tb_display_ndigit_mux;

    localparam int unsigned NDIG     = 4;
    localparam int unsigned DWELL_W  = 4;
    localparam int unsigned BRIGHT_W = 2;
    localparam int unsigned BLINK_W  = 2;

    localparam logic [6:0] GLY [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_en = '0;
    logic        blank_lz = 1'b0;
    logic [1:0]  brightness = '0;
    logic        enable = 1'b0;
    logic [7:0]  segments;
    logic [3:0]  digitselect;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_ndigit_mux #(
        .NDIG(NDIG), .DWELL_W(DWELL_W), .BRIGHT_W(BRIGHT_W), .BLINK_W(BLINK_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blink_en(blink_en),
        .blank_lz(blank_lz), .brightness(brightness), .enable(enable),
        .segments(segments), .digitselect(digitselect), .frame_tick(frame_tick)
    );

    // Reference: n = clock edges since reset; 16 cycles per digit, 64 per frame.
    function automatic logic [11:0] model_out(input int unsigned n, input logic [15:0] v,
                                              input logic [3:0] dp, input logic [3:0] bl,
                                              input logic blz, input logic en, input logic [1:0] br);
        int unsigned ph, fr;
        logic [1:0]  k;
        logic        lit, supp;
        logic [7:0]  seg;
        ph   = n % 16;
        k    = 2'((n / 16) % 4);
        fr   = (n / 64) % 4;
        lit  = en && (ph != 0) && ((ph / 4) <= 32'(br)) && !(bl[k] && fr >= 2);
        supp = blz && (k != 2'd0) && ((v >> {k, 2'b00}) == 16'd0);
        seg  = {supp ? 7'd0 : GLY[4'(v >> {k, 2'b00})], dp[k]};
        return lit ? {~(4'b0001 << k), ~seg} : {4'hF, 8'hFF};
    endfunction

    int unsigned m_n;
    logic [15:0] m_v;
    logic [3:0]  m_dp, m_bl;
    logic        m_blz;
    logic [7:0]  e_seg;
    logic [3:0]  e_dsel;
    logic        e_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0; m_v <= '0; m_dp <= '0; m_bl <= '0; m_blz <= 1'b0;
            e_seg <= 8'hFF; e_dsel <= 4'hF; e_tick <= 1'b0;
        end else begin
            {e_dsel, e_seg} <= model_out(m_n, m_v, m_dp, m_bl, m_blz, enable, brightness);
            e_tick <= (m_n % 64 == 63);
            if (m_n % 64 == 63) begin
                m_v <= value; m_dp <= dp_in; m_bl <= blink_en; m_blz <= blank_lz;
            end
            m_n <= m_n + 1;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; value = 16'h12AF; dp_in = '0; blink_en = '0;
        blank_lz = 1'b0; brightness = 2'd3; enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (segments !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", segments); end
        checks++; if (digitselect !== 4'hF) begin errors++; $display("FAIL reset_dsel got %h want f", digitselect); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    endtask

    task automatic test_first_frame();
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            checks++;
            if (segments !== e_seg || digitselect !== e_dsel || frame_tick !== e_tick) begin
                errors++;
                $display("FAIL first_frame cyc %0d seg %h/%h dsel %h/%h tick %b/%b", i, segments, e_seg, digitselect, e_dsel, frame_tick, e_tick);
            end
            if (i == 5) begin
                checks++;
                if (segments !== ~8'b11111100 || digitselect !== 4'b1110) begin
                    errors++; $display("FAIL first_zero seg %h dsel %h want 03/e", segments, digitselect);
                end
            end
            if (i == 63) begin
                checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b want 1", frame_tick); end
            end
            if (i == 69) begin
                checks++;
                if (segments !== ~8'b10001110 || digitselect !== 4'b1110) begin
                    errors++; $display("FAIL first_F seg %h dsel %h want 71/e", segments, digitselect);
                end
            end
            if (i == 117) begin
                checks++;
                if (segments !== ~8'b01100000 || digitselect !== 4'b0111) begin
                    errors++; $display("FAIL first_one seg %h dsel %h want 9f/7", segments, digitselect);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic got;
        value = 16'h0070; blank_lz = 1'b1; dp_in = 4'b0100; brightness = 2'd3;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin @(negedge clk); got = frame_tick; end
        checks++; if (!got) begin errors++; $display("FAIL blank_tick timeout got 0 want 1"); end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            checks++;
            if (segments !== e_seg || digitselect !== e_dsel || frame_tick !== e_tick) begin
                errors++;
                $display("FAIL blank cyc %0d seg %h/%h dsel %h/%h tick %b/%b", i, segments, e_seg, digitselect, e_dsel, frame_tick, e_tick);
            end
            if (i == 5) begin
                checks++; if (segments !== ~8'b11111100 || digitselect !== 4'b1110) begin
                    errors++; $display("FAIL blank_d0 seg %h dsel %h want 03/e", segments, digitselect); end
            end
            if (i == 21) begin
                checks++; if (segments !== ~8'b11100000 || digitselect !== 4'b1101) begin
                    errors++; $display("FAIL blank_d1 seg %h dsel %h want 1f/d", segments, digitselect); end
            end
            if (i == 37) begin
                checks++; if (segments !== ~8'b00000001 || digitselect !== 4'b1011) begin
                    errors++; $display("FAIL blank_d2 seg %h dsel %h want fe/b", segments, digitselect); end
            end
            if (i == 53) begin
                checks++; if (segments !== 8'hFF) begin
                    errors++; $display("FAIL blank_d3 seg %h want ff", segments); end
            end
        end
        blank_lz = 1'b0; dp_in = '0;
    endtask

    task automatic test_brightness();
        logic [15:0] mask;
        int          cnt;
        logic        got;
        for (int b = 0; b < 2; b++) begin
            brightness = (b == 0) ? 2'd0 : 2'd3;
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin @(negedge clk); got = frame_tick; end
            checks++; if (!got) begin errors++; $display("FAIL bright_tick timeout got 0 want 1"); end
            for (int d = 0; d < 4; d++) begin
                mask = '0; cnt = 0;
                for (int p = 0; p < 16; p++) begin
                    @(negedge clk);
                    checks++;
                    if (segments !== e_seg || digitselect !== e_dsel) begin
                        errors++;
                        $display("FAIL bright cyc %0d seg %h/%h dsel %h/%h", p, segments, e_seg, digitselect, e_dsel);
                    end
                    if (digitselect !== 4'hF) begin mask[p] = 1'b1; cnt++; end
                end
                checks++;
                if (mask !== ((b == 0) ? 16'h000E : 16'hFFFE) || cnt != ((b == 0) ? 3 : 15)) begin
                    errors++;
                    $display("FAIL bright_duty br %0d digit %0d mask %h cnt %0d want %h", b * 3, d, mask, cnt, (b == 0) ? 16'h000E : 16'hFFFE);
                end
            end
        end
    endtask

    task automatic test_blink();
        int   lit0, lit1, fr;
        logic got;
        blink_en = 4'b0001; brightness = 2'd3; value = 16'h4321;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin @(negedge clk); got = frame_tick; end
        checks++; if (!got) begin errors++; $display("FAIL blink_tick timeout got 0 want 1"); end
        for (int f = 0; f < 4; f++) begin
            fr = int'((m_n / 64) % 4);
            lit0 = 0; lit1 = 0;
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                checks++;
                if (segments !== e_seg || digitselect !== e_dsel) begin
                    errors++;
                    $display("FAIL blink cyc %0d seg %h/%h dsel %h/%h", i, segments, e_seg, digitselect, e_dsel);
                end
                if (digitselect === 4'b1110) lit0++;
                if (digitselect === 4'b1101) lit1++;
            end
            checks++; if (lit0 != ((fr < 2) ? 15 : 0)) begin
                errors++; $display("FAIL blink_d0 frame %0d lit %0d want %0d", fr, lit0, (fr < 2) ? 15 : 0); end
            checks++; if (lit1 != 15) begin
                errors++; $display("FAIL blink_d1 frame %0d lit %0d want 15", fr, lit1); end
        end
        blink_en = '0;
    endtask

    task automatic test_midframe();
        logic got;
        int   last, nt;
        value = 16'h1234;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin @(negedge clk); got = frame_tick; end
        checks++; if (!got) begin errors++; $display("FAIL mid_tick timeout got 0 want 1"); end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                checks++;
                if (segments !== e_seg || digitselect !== e_dsel || frame_tick !== e_tick) begin
                    errors++;
                    $display("FAIL mid cyc %0d seg %h/%h dsel %h/%h tick %b/%b", i, segments, e_seg, digitselect, e_dsel, frame_tick, e_tick);
                end
                if (f == 0 && i == 21) value = 16'h5678;
                if (f == 0 && i == 25) begin
                    checks++; if (segments !== ~8'b11110010) begin
                        errors++; $display("FAIL mid_hold1 seg %h want 0d", segments); end
                end
                if (i == 37) begin
                    checks++; if (segments !== ((f == 0) ? ~8'b11011010 : ~8'b10111110)) begin
                        errors++; $display("FAIL mid_d2 frame %0d seg %h want %h", f, segments, (f == 0) ? ~8'b11011010 : ~8'b10111110); end
                end
            end
        end
        last = -1; nt = 0;
        for (int c = 0; c < 192; c++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                if (last >= 0) begin
                    checks++; if (c - last != 64) begin
                        errors++; $display("FAIL tick_gap got %0d want 64", c - last); end
                end
                last = c; nt++;
            end
        end
        checks++; if (nt != 3) begin errors++; $display("FAIL tick_count got %0d want 3", nt); end
    endtask

    task automatic test_enable();
        logic got;
        int   nt;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin @(negedge clk); got = (digitselect !== 4'hF); end
        checks++; if (!got) begin errors++; $display("FAIL en_lit timeout got 0 want 1"); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (segments !== 8'hFF || digitselect !== 4'hF) begin
            errors++; $display("FAIL en_dark seg %h dsel %h want ff/f", segments, digitselect); end
        nt = 0;
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            checks++;
            if (segments !== e_seg || digitselect !== e_dsel || frame_tick !== e_tick) begin
                errors++;
                $display("FAIL en_off cyc %0d seg %h/%h dsel %h/%h tick %b/%b", c, segments, e_seg, digitselect, e_dsel, frame_tick, e_tick);
            end
            if (frame_tick === 1'b1) nt++;
        end
        checks++; if (nt != 2) begin errors++; $display("FAIL en_ticks got %0d want 2", nt); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic got;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin @(negedge clk); got = (digitselect !== 4'hF); end
        checks++; if (!got) begin errors++; $display("FAIL rmid_lit timeout got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (segments !== 8'hFF || digitselect !== 4'hF || frame_tick !== 1'b0) begin
            errors++; $display("FAIL rmid_dark seg %h dsel %h tick %b want ff/f/0", segments, digitselect, frame_tick); end
        @(negedge clk);
        value = 16'hBEEF;
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (segments !== e_seg || digitselect !== e_dsel || frame_tick !== e_tick) begin
                errors++;
                $display("FAIL rmid cyc %0d seg %h/%h dsel %h/%h tick %b/%b", i, segments, e_seg, digitselect, e_dsel, frame_tick, e_tick);
            end
            if (i == 5) begin
                checks++; if (segments !== ~8'b11111100 || digitselect !== 4'b1110) begin
                    errors++; $display("FAIL rmid_restart seg %h dsel %h want 03/e", segments, digitselect); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            checks++;
            if (segments !== e_seg || digitselect !== e_dsel || frame_tick !== e_tick) begin
                errors++;
                $display("FAIL random cyc %0d seg %h/%h dsel %h/%h tick %b/%b", i, segments, e_seg, digitselect, e_dsel, frame_tick, e_tick);
            end
            if ($urandom_range(5) == 0) begin
                value      = 16'($urandom);
                if ($urandom_range(1) == 0) value = value & 16'h00FF;
                dp_in      = 4'($urandom);
                blink_en   = 4'($urandom);
                blank_lz   = 1'($urandom);
                brightness = 2'($urandom);
                enable     = ($urandom_range(7) != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_blank();
        test_brightness();
        test_blink();
        test_midframe();
        test_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
